// File: rtl/btn_conditioner.sv
// Button pad conditioner: two-flop synchroniser, debounce filter and a
// press/long-press FSM producing registered single-cycle events and a press count.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 64,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       held_long,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic          IDLE_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  logic          sync1_r;
  logic          sync2_r;
  logic          pressed_s;
  logic          stable_r;
  logic [DW-1:0] deb_cnt_r;
  logic          toggle_s;
  logic          rise_s;
  logic          fall_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [HW-1:0] hold_cnt_r;
  logic          press_pulse_s;
  logic          release_pulse_s;
  logic          long_pulse_s;
  logic          held_long_s;
  logic          press_pulse_r;
  logic          release_pulse_r;
  logic          long_pulse_r;
  logic          held_long_r;
  logic [7:0]    press_count_r;

  // Two-flop synchroniser; only sync1_r may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= IDLE_LVL;
      sync2_r <= IDLE_LVL;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = sync2_r ^ IDLE_LVL;
  assign toggle_s  = (pressed_s != stable_r) && (deb_cnt_r == DEB_LAST);
  assign rise_s    = toggle_s & ~stable_r;
  assign fall_s    = toggle_s & stable_r;

  // Debounce: any agreeing sample restarts the run of disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r  <= 1'b0;
      deb_cnt_r <= '0;
    end else if (pressed_s == stable_r) begin
      deb_cnt_r <= '0;
    end else if (toggle_s) begin
      stable_r  <= ~stable_r;
      deb_cnt_r <= '0;
    end else begin
      deb_cnt_r <= deb_cnt_r + DW'(1);
    end
  end

  // FSM state register, hold timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      hold_cnt_r      <= '0;
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
      long_pulse_r    <= 1'b0;
      held_long_r     <= 1'b0;
      press_count_r   <= 8'd0;
    end else begin
      state_r         <= state_nxt_s;
      press_pulse_r   <= press_pulse_s;
      release_pulse_r <= release_pulse_s;
      long_pulse_r    <= long_pulse_s;
      held_long_r     <= held_long_s;
      if (press_pulse_s) begin
        press_count_r <= press_count_r + 8'd1;
      end else begin
        press_count_r <= press_count_r;
      end
      if (state_r == ST_PRESSED && state_nxt_s == ST_PRESSED) begin
        hold_cnt_r <= hold_cnt_r + HW'(1);
      end else if (state_nxt_s == ST_PRESSED) begin
        hold_cnt_r <= '0;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  // Next-state logic; a release on the long-press edge takes priority.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) state_nxt_s = ST_PRESSED;
        else        state_nxt_s = ST_IDLE;
      end
      ST_PRESSED: begin
        if (fall_s)                         state_nxt_s = ST_IDLE;
        else if (hold_cnt_r == HOLD_LAST)   state_nxt_s = ST_LONG;
        else                                state_nxt_s = ST_PRESSED;
      end
      ST_LONG: begin
        if (fall_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_LONG;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode, registered on the same edge as the state change.
  always_comb begin
    press_pulse_s   = 1'b0;
    release_pulse_s = 1'b0;
    long_pulse_s    = 1'b0;
    held_long_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        press_pulse_s = rise_s;
      end
      ST_PRESSED: begin
        release_pulse_s = fall_s;
        long_pulse_s    = (state_nxt_s == ST_LONG);
        held_long_s     = (state_nxt_s == ST_LONG);
      end
      ST_LONG: begin
        release_pulse_s = fall_s;
        held_long_s     = (state_nxt_s == ST_LONG);
      end
      default: begin
        press_pulse_s = 1'b0;
      end
    endcase
  end

  assign btn_level     = stable_r;
  assign press_pulse   = press_pulse_r;
  assign release_pulse = release_pulse_r;
  assign long_pulse    = long_pulse_r;
  assign held_long     = held_long_r;
  assign press_count   = press_count_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: edges are counted from the first clk
// edge after btn_in changes; outputs are sampled on the falling edge.
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       held_long;
  logic [7:0] press_count;

  int checks   = 0;
  int failures = 0;
  int n_press   = 0;
  int n_release = 0;
  int n_long    = 0;
  int n_both    = 0;
  logic [7:0] exp_count;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(16),
    .LONG_CYCLES    (64),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .held_long    (held_long),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (press_pulse === 1'b1) n_press++;
    if (release_pulse === 1'b1) n_release++;
    if (long_pulse === 1'b1) n_long++;
    if (press_pulse === 1'b1 && release_pulse === 1'b1) n_both++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_in = 1'b1;
    repeat (5) tick();
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse, held_long} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 00000",
               {btn_level, press_pulse, release_pulse, long_pulse, held_long});
    end
    checks++;
    if (press_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d want 0", press_count);
    end
    rst = 1'b0;
    repeat (50) tick();
    checks++;
    if ({btn_level, held_long, press_count} !== 10'd0) begin
      failures++;
      $display("FAIL idle_outputs: level=%b held=%b count=%0d want 0",
               btn_level, held_long, press_count);
    end
    checks++;
    if (n_press + n_release + n_long !== 0) begin
      failures++;
      $display("FAIL idle_pulses: got %0d want 0", n_press + n_release + n_long);
    end
    exp_count = 8'd0;
  endtask

  task automatic test_clean();
    int p0, r0, l0, first;
    logic lvl17;
    p0 = n_press; r0 = n_release; l0 = n_long;
    first = -1; lvl17 = 1'b1;
    btn_in = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (press_pulse === 1'b1 && first < 0) first = k;
      if (k == 17) lvl17 = btn_level;
    end
    exp_count = exp_count + 8'd1;
    checks++;
    if (first !== 18) begin failures++; $display("FAIL clean_press_edge: got %0d want 18", first); end
    checks++;
    if (lvl17 !== 1'b0) begin failures++; $display("FAIL clean_level_early: got %b want 0", lvl17); end
    checks++;
    if (btn_level !== 1'b1) begin failures++; $display("FAIL clean_level: got %b want 1", btn_level); end
    checks++;
    if (n_press - p0 !== 1) begin failures++; $display("FAIL clean_press_width: got %0d want 1", n_press - p0); end
    checks++;
    if (press_count !== exp_count) begin failures++; $display("FAIL clean_count: got %0d want %0d", press_count, exp_count); end
    btn_in = 1'b1;
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (release_pulse === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first !== 18) begin failures++; $display("FAIL clean_release_edge: got %0d want 18", first); end
    checks++;
    if (btn_level !== 1'b0) begin failures++; $display("FAIL clean_release_level: got %b want 0", btn_level); end
    checks++;
    if (n_release - r0 !== 1 || n_long - l0 !== 0) begin
      failures++;
      $display("FAIL clean_release_pulses: release=%0d long=%0d want 1 0", n_release - r0, n_long - l0);
    end
  endtask

  task automatic test_bounce();
    int p0, r0, first;
    p0 = n_press; r0 = n_release;
    for (int i = 0; i < 6; i++) begin
      btn_in = 1'b0;
      repeat (5) tick();
      btn_in = 1'b1;
      repeat (3) tick();
    end
    checks++;
    if (n_press - p0 !== 0 || n_release - r0 !== 0 || btn_level !== 1'b0) begin
      failures++;
      $display("FAIL bounce_quiet: press=%0d release=%0d level=%b want 0 0 0",
               n_press - p0, n_release - r0, btn_level);
    end
    btn_in = 1'b0;
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (press_pulse === 1'b1 && first < 0) first = k;
    end
    exp_count = exp_count + 8'd1;
    checks++;
    if (first !== 18) begin failures++; $display("FAIL bounce_press_edge: got %0d want 18", first); end
    checks++;
    if (press_count !== exp_count || n_press - p0 !== 1) begin
      failures++;
      $display("FAIL bounce_count: got %0d (%0d pulses) want %0d (1 pulse)", press_count, n_press - p0, exp_count);
    end
    btn_in = 1'b1;
    repeat (40) tick();
  endtask

  task automatic test_boundary();
    int p0, r0;
    p0 = n_press; r0 = n_release;
    btn_in = 1'b0;
    repeat (15) tick();
    btn_in = 1'b1;
    repeat (40) tick();
    checks++;
    if (n_press - p0 !== 0 || press_count !== exp_count) begin
      failures++;
      $display("FAIL glitch15_rejected: pulses=%0d count=%0d want 0 %0d", n_press - p0, press_count, exp_count);
    end
    btn_in = 1'b0;
    repeat (16) tick();
    btn_in = 1'b1;
    repeat (40) tick();
    exp_count = exp_count + 8'd1;
    checks++;
    if (n_press - p0 !== 1 || n_release - r0 !== 1 || press_count !== exp_count) begin
      failures++;
      $display("FAIL hold16_accepted: press=%0d release=%0d count=%0d want 1 1 %0d",
               n_press - p0, n_release - r0, press_count, exp_count);
    end
  endtask

  task automatic test_long();
    int l0, fp, fl, fr;
    logic held81, held_rel, held_pre;
    l0 = n_long;
    fp = -1; fl = -1; fr = -1;
    held81 = 1'b1; held_rel = 1'b1; held_pre = 1'b0;
    btn_in = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (press_pulse === 1'b1 && fp < 0) fp = k;
      if (long_pulse === 1'b1 && fl < 0) fl = k;
      if (k == 81) held81 = held_long;
    end
    exp_count = exp_count + 8'd1;
    checks++;
    if (fp !== 18) begin failures++; $display("FAIL long_press_edge: got %0d want 18", fp); end
    checks++;
    if (fl !== 82) begin failures++; $display("FAIL long_pulse_edge: got %0d want 82", fl); end
    checks++;
    if (held81 !== 1'b0 || held_long !== 1'b1) begin
      failures++;
      $display("FAIL long_held: at81=%b at120=%b want 0 1", held81, held_long);
    end
    checks++;
    if (n_long - l0 !== 1) begin failures++; $display("FAIL long_single: got %0d want 1", n_long - l0); end
    btn_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 17) held_pre = held_long;
      if (release_pulse === 1'b1 && fr < 0) begin fr = k; held_rel = held_long; end
    end
    checks++;
    if (fr !== 18) begin failures++; $display("FAIL long_release_edge: got %0d want 18", fr); end
    checks++;
    if (held_pre !== 1'b1 || held_rel !== 1'b0) begin
      failures++;
      $display("FAIL long_held_clear: before=%b at_release=%b want 1 0", held_pre, held_rel);
    end
    checks++;
    if (n_long - l0 !== 1 || press_count !== exp_count) begin
      failures++;
      $display("FAIL long_totals: long=%0d count=%0d want 1 %0d", n_long - l0, press_count, exp_count);
    end
  endtask

  task automatic test_release_wins();
    int l0, r0, fr;
    logic any_held;
    l0 = n_long; r0 = n_release;
    fr = -1; any_held = 1'b0;
    btn_in = 1'b0;
    repeat (64) tick();
    exp_count = exp_count + 8'd1;
    btn_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (held_long === 1'b1) any_held = 1'b1;
      if (release_pulse === 1'b1 && fr < 0) fr = k;
    end
    checks++;
    if (fr !== 18 || n_release - r0 !== 1) begin
      failures++;
      $display("FAIL race_release: edge=%0d pulses=%0d want 18 1", fr, n_release - r0);
    end
    checks++;
    if (n_long - l0 !== 0 || any_held !== 1'b0) begin
      failures++;
      $display("FAIL race_no_long: long=%0d held=%b want 0 0", n_long - l0, any_held);
    end
  endtask

  task automatic test_wrap();
    int p0, r0;
    logic [7:0] prev;
    logic wrapped;
    p0 = n_press; r0 = n_release;
    wrapped = 1'b0;
    prev = press_count;
    for (int i = 0; i < 256; i++) begin
      btn_in = 1'b0;
      repeat (20) tick();
      btn_in = 1'b1;
      repeat (20) tick();
      exp_count = exp_count + 8'd1;
      checks++;
      if (press_count !== exp_count) begin
        failures++;
        $display("FAIL wrap_count[%0d]: got %0d want %0d", i, press_count, exp_count);
      end
      if (prev == 8'd255 && press_count == 8'd0) wrapped = 1'b1;
      prev = press_count;
    end
    checks++;
    if (wrapped !== 1'b1) begin failures++; $display("FAIL wrap_seen: got %b want 1", wrapped); end
    checks++;
    if (n_press - p0 !== 256 || n_release - r0 !== 256) begin
      failures++;
      $display("FAIL wrap_pulses: press=%0d release=%0d want 256 256", n_press - p0, n_release - r0);
    end
    checks++;
    if (n_both !== 0) begin failures++; $display("FAIL pulse_overlap: got %0d want 0", n_both); end
  endtask

  task automatic test_reset_mid();
    int r0, first;
    btn_in = 1'b0;
    repeat (39) tick();
    checks++;
    if (btn_level !== 1'b1) begin failures++; $display("FAIL mid_precondition: got %b want 1", btn_level); end
    r0 = n_release;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse, held_long} !== 5'b00000 || press_count !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %b count=%0d want 00000 0",
               {btn_level, press_pulse, release_pulse, long_pulse, held_long}, press_count);
    end
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (press_pulse === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first !== 18) begin failures++; $display("FAIL mid_repress_edge: got %0d want 18", first); end
    checks++;
    if (press_count !== 8'd1 || n_release - r0 !== 0) begin
      failures++;
      $display("FAIL mid_repress_state: count=%0d releases=%0d want 1 0", press_count, n_release - r0);
    end
    btn_in = 1'b1;
    repeat (40) tick();
  endtask

  initial begin
    rst = 1'b1;
    btn_in = 1'b1;
    exp_count = 8'd0;
    test_reset();
    test_clean();
    test_bounce();
    test_boundary();
    test_long();
    test_release_wins();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
